soi_injector: RTL and testbench

Drives a signal of interest (SOI) into the design under test at cycle-exact times scheduled by the software side, the write-direction counterpart of our SOI read-out path. Software-facing glue, DPI or otherwise, pushes (value, target cycle) commands through a valid/ready port. The block queues them, compares each against a free-running cycle counter, and updates the registered `soi_out` when the target cycle is reached. It sits between the DPI command shim and the DUT input it overrides.

---
 rtl/soi_inject_pkg.sv | 36 +++
 rtl/soi_cmd_fifo.sv | 64 ++++++
 rtl/soi_injector.sv | 137 +++++++++++++
 tb/tb_soi_injector.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soi_inject_pkg.sv
// Shared types and wrap-safe due/late helpers for the SOI injector.
package soi_inject_pkg;

    localparam int SOI_DATA_W = 8;
    localparam int SOI_CYC_W  = 32;

    typedef struct packed {
        logic [SOI_DATA_W-1:0] data;
        logic [SOI_CYC_W-1:0]  cycle;
    } soi_cmd_t;

    typedef enum logic {
        S_IDLE,
        S_ARMED
    } soi_state_t;

    // Operands are zero-extended counter/target values of width w (< 64).
    function automatic logic is_due(input logic [63:0] count,
                                    input logic [63:0] target,
                                    input int unsigned w);
        logic [63:0] d;
        d = count - target;
        return ((d >> (w - 1)) & 64'd1) == 64'd0;
    endfunction

    function automatic logic is_late(input logic [63:0] count,
                                     input logic [63:0] target,
                                     input int unsigned w);
        logic [63:0] d;
        logic [63:0] mask;
        d    = count - target;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return is_due(count, target, w) && ((d & mask) != 64'd0);
    endfunction

endpackage

// File: rtl/soi_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; clr empties it on the next edge.
module soi_cmd_fifo
    import soi_inject_pkg::*;
#(
    parameter type T     = soi_cmd_t,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        push,
    input  T            wr_data,
    input  logic        pop,
    output T            rd_data,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push && rst_n && !clr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/soi_injector.sv
// Applies queued (value, target cycle) commands to soi_out at cycle-exact times.
//   state   | meaning
//   S_IDLE  | arm register empty; pop the FIFO head when one is queued
//   S_ARMED | arm register holds the next command, waiting for its target cycle
module soi_injector
    import soi_inject_pkg::*;
#(
    parameter int              DATA_W    = SOI_DATA_W,
    parameter int              CYC_W     = SOI_CYC_W,
    parameter int              DEPTH     = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [CYC_W-1:0]  cmd_cycle,
    input  logic              flush,
    output logic [DATA_W-1:0] soi_out,
    output logic              applied,
    output logic              late,
    output logic [CYC_W-1:0]  cycle_count,
    output logic              idle
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CYC_W-1:0]  cycle;
    } cmd_t;

    soi_state_t        state_q, state_d;
    cmd_t              arm_q, arm_d;
    logic [DATA_W-1:0] soi_q, soi_d;
    logic              applied_q, applied_d;
    logic              late_q, late_d;
    logic [CYC_W-1:0]  cycle_count_q;

    cmd_t              fifo_wr;
    cmd_t              fifo_rd;
    logic [AW:0]       fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              have_next;
    logic              due;
    logic              overdue;

    assign fifo_wr   = '{data: cmd_data, cycle: cmd_cycle};
    assign fifo_push = cmd_valid && !fifo_full && !flush;
    assign have_next = (fifo_count != '0);
    assign due       = is_due(64'(cycle_count_q), 64'(arm_q.cycle), CYC_W);
    assign overdue   = is_late(64'(cycle_count_q), 64'(arm_q.cycle), CYC_W);

    soi_cmd_fifo #(
        .T     (cmd_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .push    (fifo_push),
        .wr_data (fifo_wr),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        arm_d     = arm_q;
        soi_d     = soi_q;
        applied_d = 1'b0;
        late_d    = 1'b0;
        fifo_pop  = 1'b0;
        // Flush wins over both an apply and a refill in the same cycle.
        if (flush) begin
            state_d = S_IDLE;
            arm_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (have_next) begin
                        fifo_pop = 1'b1;
                        arm_d    = fifo_rd;
                        state_d  = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (due) begin
                        soi_d     = arm_q.data;
                        applied_d = 1'b1;
                        late_d    = overdue;
                        if (have_next) begin
                            fifo_pop = 1'b1;
                            arm_d    = fifo_rd;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            arm_q         <= '0;
            soi_q         <= RESET_VAL;
            applied_q     <= 1'b0;
            late_q        <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            arm_q         <= arm_d;
            soi_q         <= soi_d;
            applied_q     <= applied_d;
            late_q        <= late_d;
            cycle_count_q <= cycle_count_q + CYC_W'(1);
        end
    end

    assign cmd_ready   = !fifo_full;
    assign idle        = fifo_empty && (state_q == S_IDLE);
    assign soi_out     = soi_q;
    assign applied     = applied_q;
    assign late        = late_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_soi_injector.sv
// Bench for soi_injector: timeline-level reference model, per-cycle compare, directed and random stimulus.
module tb_soi_injector;

    localparam int DW    = 8;
    localparam int CW    = 8;
    localparam int DEPTH = 4;
    localparam int MODW  = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] cmd_data = '0;
    logic [CW-1:0] cmd_cycle = '0;
    logic          flush = 1'b0;
    logic [DW-1:0] soi_out;
    logic          applied;
    logic          late;
    logic [CW-1:0] cycle_count;
    logic          idle;

    always #5 clk = ~clk;

    soi_injector #(
        .DATA_W    (DW),
        .CYC_W     (CW),
        .DEPTH     (DEPTH),
        .RESET_VAL (8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_data    (cmd_data),
        .cmd_cycle   (cmd_cycle),
        .flush       (flush),
        .soi_out     (soi_out),
        .applied     (applied),
        .late        (late),
        .cycle_count (cycle_count),
        .idle        (idle)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending commands in order; the head may apply only once it has
    // been armed (one edge after it is both queued and the previous one is gone).
    typedef struct {
        logic [7:0] data;
        logic [7:0] cyc;
    } mcmd_t;

    mcmd_t      mq[$];
    int         head_arm = 0;
    int         edge_n = 0;
    int         mcnt = 0;
    logic [7:0] e_soi = 8'h00;
    bit         e_app = 0;
    bit         e_late = 0;
    bit         e_ready = 1;
    bit         e_idle = 1;
    bit         m_acc = 0;
    bit         m_valid = 0;

    task automatic model_step();
        int d;
        int armed;
        bit rdy;
        edge_n++;
        m_acc  = 0;
        e_app  = 0;
        e_late = 0;
        if (!rst_n) begin
            mq.delete();
            mcnt    = 0;
            e_soi   = 8'h00;
            m_valid = 1;
        end else begin
            armed = (mq.size() > 0 && head_arm <= edge_n - 1) ? 1 : 0;
            rdy   = (mq.size() - armed) < DEPTH;
            if (flush) begin
                mq.delete();
            end else begin
                if (armed == 1) begin
                    d = (mcnt - int'(mq[0].cyc) + MODW) % MODW;
                    if (d < MODW / 2) begin
                        e_soi  = mq[0].data;
                        e_app  = 1;
                        e_late = (d != 0);
                        void'(mq.pop_front());
                        head_arm = edge_n;
                    end
                end
                if (cmd_valid && rdy) begin
                    if (mq.size() == 0) head_arm = edge_n + 1;
                    mq.push_back('{cmd_data, cmd_cycle});
                    m_acc = 1;
                end
            end
            mcnt = (mcnt + 1) % MODW;
        end
        armed   = (mq.size() > 0 && head_arm <= edge_n) ? 1 : 0;
        e_ready = (mq.size() - armed) < DEPTH;
        e_idle  = (mq.size() == 0);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("soi_out", 32'(soi_out), 32'(e_soi));
            chk("applied", 32'(applied), 32'(e_app));
            chk("late", 32'(late), 32'(e_late));
            chk("cycle_count", 32'(cycle_count), 32'(mcnt));
            chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
            chk("idle", 32'(idle), 32'(e_idle));
        end
    end

    task automatic wait_cnt(input int v);
        int k = 0;
        while (mcnt != v && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (mcnt != v) begin
            checks++;
            errors++;
            $display("FAIL wait_cnt actual=%0d required=%0d", mcnt, v);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [7:0] c);
        int k = 0;
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_cycle = c;
        do begin
            @(negedge clk);
            k++;
        end while (!m_acc && k < 50);
        cmd_valid = 1'b0;
        if (!m_acc) begin
            checks++;
            errors++;
            $display("FAIL push_accept actual=timeout required=accepted data=%0h", d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int t;
        int last_t;
        int r;

        // Reset held for three edges
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_soi", 32'(soi_out), 32'h00);
        chk("rst_cnt", 32'(cycle_count), 32'd0);
        chk("rst_applied", 32'(applied), 32'd0);
        chk("rst_late", 32'(late), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_idle", 32'(idle), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_cnt", 32'(cycle_count), 32'd1);

        // Single future command
        wait_cnt(2);
        push(8'hA5, 8'd10);
        wait_cnt(11);
        chk("single_soi", 32'(soi_out), 32'hA5);
        chk("single_applied", 32'(applied), 32'd1);
        chk("single_late", 32'(late), 32'd0);
        chk("single_model_app", 32'(e_app), 32'd1);
        @(negedge clk);
        chk("single_idle", 32'(idle), 32'd1);

        // Past target: applied two edges after the handshake
        wait_cnt(20);
        push(8'h3C, 8'd5);
        @(negedge clk);
        chk("late_early", 32'(applied), 32'd0);
        @(negedge clk);
        chk("late_applied", 32'(applied), 32'd1);
        chk("late_late", 32'(late), 32'd1);
        chk("late_soi", 32'(soi_out), 32'h3C);
        chk("late_cnt", 32'(cycle_count), 32'd23);

        // Fill FIFO plus arm register, then back-to-back applies
        wait_cnt(0);
        push(8'h11, 8'd30);
        push(8'h22, 8'd31);
        push(8'h33, 8'd32);
        push(8'h44, 8'd33);
        push(8'h55, 8'd34);
        chk("full_ready", 32'(cmd_ready), 32'd0);
        wait_cnt(31);
        chk("b2b_first", 32'(soi_out), 32'h11);
        @(negedge clk);
        chk("b2b_second", 32'(soi_out), 32'h22);
        chk("b2b_second_app", 32'(applied), 32'd1);
        wait_cnt(35);
        chk("b2b_fifth", 32'(soi_out), 32'h55);
        chk("b2b_fifth_app", 32'(applied), 32'd1);
        chk("b2b_fifth_late", 32'(late), 32'd0);
        chk("b2b_model_soi", 32'(e_soi), 32'h55);

        // Target across the counter wrap
        wait_cnt(250);
        push(8'h77, 8'd2);
        wait_cnt(0);
        chk("wrap_not_yet", 32'(applied), 32'd0);
        chk("wrap_old_soi", 32'(soi_out), 32'h55);
        wait_cnt(3);
        chk("wrap_applied", 32'(applied), 32'd1);
        chk("wrap_late", 32'(late), 32'd0);
        chk("wrap_soi", 32'(soi_out), 32'h77);

        // Flush in the cycle the first queued command is due
        wait_cnt(10);
        push(8'h81, 8'd40);
        push(8'h82, 8'd41);
        push(8'h83, 8'd42);
        wait_cnt(40);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_applied", 32'(applied), 32'd0);
        chk("flush_soi", 32'(soi_out), 32'h77);
        chk("flush_idle", 32'(idle), 32'd1);
        chk("flush_cnt", 32'(cycle_count), 32'd41);

        // Reset in the same situation
        wait_cnt(50);
        push(8'h91, 8'd60);
        push(8'h92, 8'd61);
        push(8'h93, 8'd62);
        wait_cnt(60);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_soi", 32'(soi_out), 32'h00);
        chk("mrst_cnt", 32'(cycle_count), 32'd0);
        chk("mrst_idle", 32'(idle), 32'd1);
        chk("mrst_ready", 32'(cmd_ready), 32'd1);

        // Random traffic with occasional flush and reset
        last_t = mcnt;
        for (int i = 0; i < 2000; i++) begin
            if (m_acc) cmd_valid = 1'b0;
            if (!cmd_valid && $urandom_range(0, 2) == 0) begin
                r = int'($urandom_range(0, 24));
                t = (mcnt + r + MODW - 6) % MODW;
                if (((t - last_t + MODW) % MODW) >= MODW / 2) t = last_t;
                last_t    = t;
                cmd_cycle = 8'(t);
                cmd_data  = 8'($urandom_range(0, 255));
                cmd_valid = 1'b1;
            end
            flush = ($urandom_range(0, 49) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        flush     = 1'b0;
        rst_n     = 1'b1;
        repeat (60) @(negedge clk);
        chk("drain_idle", 32'(idle), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
